// File: rtl/recepcion.sv
// 8N1 UART receiver: oversampled start-edge detection, mid-bit sampling,
// byte output with a one-cycle done pulse and a frame_err pulse on a bad stop bit.
module recepcion #(
    parameter int OVERSAMPLE = 16,
    parameter int count      = 8
) (
    input  logic             clk_div,
    input  logic             rst_n,
    input  logic             rx,
    output logic [count-1:0] dout,
    output logic             done,
    output logic             frame_err,
    output logic             busy
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] CNT_MID  = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] CNT_END  = CW'(OVERSAMPLE - 1);
    localparam logic [2:0]    BIT_LAST = 3'(count - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t           state, state_next;
    logic             sync1, sync2;
    logic [CW-1:0]    cnt;
    logic [2:0]       bitpos;
    logic [count-1:0] data;
    logic             take_bit, stop_ok, stop_bad;
    logic             rx_s;

    assign rx_s = sync2;
    assign busy = (state != IDLE);

    always_comb begin
        state_next = state;
        take_bit   = 1'b0;
        stop_ok    = 1'b0;
        stop_bad   = 1'b0;
        case (state)
            IDLE:  if (!rx_s) state_next = START;
            // A start bit that is high again at its midpoint was noise.
            START: if (cnt == CNT_MID) state_next = rx_s ? IDLE : DATA;
            DATA: begin
                if (cnt == CNT_END) begin
                    take_bit = 1'b1;
                    if (bitpos == BIT_LAST) state_next = STOP;
                end
            end
            // Leaving at mid stop bit gives half a bit of slack for the next start edge.
            STOP: begin
                if (cnt == CNT_END) begin
                    state_next = IDLE;
                    stop_ok    = rx_s;
                    stop_bad   = !rx_s;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_div) begin
        if (!rst_n) begin
            state     <= IDLE;
            sync1     <= 1'b1;
            sync2     <= 1'b1;
            cnt       <= '0;
            bitpos    <= '0;
            data      <= '0;
            dout      <= '0;
            done      <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_next;
            sync1     <= rx;
            sync2     <= sync1;
            done      <= stop_ok;
            frame_err <= stop_bad;

            if (state == IDLE || state_next != state || take_bit)
                cnt <= '0;
            else
                cnt <= cnt + CW'(1);

            if (state == START && state_next == DATA)
                bitpos <= '0;
            else if (take_bit && bitpos != BIT_LAST)
                bitpos <= bitpos + 3'd1;

            if (take_bit)
                data[bitpos] <= rx_s;

            if (stop_ok)
                dout <= data;
        end
    end

endmodule

// File: tb/tb_recepcion.sv
// Directed bench for recepcion: frames driven on rx at 16 cycles per bit,
// outputs sampled on the falling edge of clk_div.
module tb_recepcion;

    logic       clk_div = 1'b0;
    logic       rst_n   = 1'b0;
    logic       rx      = 1'b1;
    logic [7:0] dout;
    logic       done, frame_err, busy;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk_div = ~clk_div;

    recepcion #(.OVERSAMPLE(16), .count(8)) dut (
        .clk_div   (clk_div),
        .rst_n     (rst_n),
        .rx        (rx),
        .dout      (dout),
        .done      (done),
        .frame_err (frame_err),
        .busy      (busy)
    );

    // Event recorder: pulse counts, busy cycles, and dout/cycle at every done.
    int         cyc = 0;
    int         done_n = 0, fe_n = 0, both_n = 0, busy_n = 0;
    logic [7:0] dq[$];
    int         dt[$];

    always @(posedge clk_div) cyc <= cyc + 1;

    always @(negedge clk_div) begin
        if (done) begin
            done_n <= done_n + 1;
            dq.push_back(dout);
            dt.push_back(cyc);
        end
        if (frame_err) fe_n <= fe_n + 1;
        if (done && frame_err) both_n <= both_n + 1;
        if (busy) busy_n <= busy_n + 1;
    end

    function automatic logic [7:0] last_dout();
        return (dq.size() > 0) ? dq[dq.size()-1] : 8'hxx;
    endfunction

    task automatic send_frame(input logic [7:0] b, input logic stop,
                              input int per_even, input int per_odd);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = bits[i];
            repeat ((i % 2 == 0) ? per_even : per_odd) @(negedge clk_div);
        end
        rx = 1'b1;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk_div);
        n_total++; if (dout !== 8'h00) $display("FAIL reset_dout got %h want 00", dout); else n_pass++;
        n_total++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else n_pass++;
        n_total++; if (frame_err !== 1'b0) $display("FAIL reset_frame_err got %b want 0", frame_err); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
        rst_n = 1'b1;
        repeat (5) @(negedge clk_div);
    endtask

    task automatic test_frame();
        int d0, f0, b0, t0;
        d0 = done_n; f0 = fe_n; b0 = busy_n; t0 = cyc;
        send_frame(8'hA5, 1'b1, 16, 16);
        repeat (10) @(negedge clk_div);
        n_total++; if (done_n - d0 !== 1) $display("FAIL frame_done_count got %0d want 1", done_n - d0); else n_pass++;
        n_total++; if (last_dout() !== 8'hA5) $display("FAIL frame_dout got %h want a5", last_dout()); else n_pass++;
        n_total++; if (fe_n - f0 !== 0) $display("FAIL frame_err_count got %0d want 0", fe_n - f0); else n_pass++;
        n_total++;
        if (dt.size() == 0 || dt[dt.size()-1] - t0 < 154 || dt[dt.size()-1] - t0 > 156)
            $display("FAIL frame_latency got %0d want 155+/-1", (dt.size() > 0) ? dt[dt.size()-1] - t0 : -1);
        else n_pass++;
        n_total++; if (busy_n - b0 !== 152) $display("FAIL frame_busy_cycles got %0d want 152", busy_n - b0); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL frame_busy_after got %b want 0", busy); else n_pass++;
    endtask

    task automatic test_glitch();
        int d0, f0, b0;
        d0 = done_n; f0 = fe_n; b0 = busy_n;
        rx = 1'b0;
        repeat (4) @(negedge clk_div);
        rx = 1'b1;
        repeat (12) @(negedge clk_div);
        n_total++; if (busy !== 1'b0) $display("FAIL glitch_busy got %b want 0", busy); else n_pass++;
        repeat (10) @(negedge clk_div);
        n_total++; if (busy_n - b0 !== 8) $display("FAIL glitch_busy_cycles got %0d want 8", busy_n - b0); else n_pass++;
        n_total++; if (done_n - d0 !== 0) $display("FAIL glitch_done got %0d want 0", done_n - d0); else n_pass++;
        n_total++; if (fe_n - f0 !== 0) $display("FAIL glitch_frame_err got %0d want 0", fe_n - f0); else n_pass++;
        n_total++; if (dout !== 8'hA5) $display("FAIL glitch_dout got %h want a5", dout); else n_pass++;
    endtask

    task automatic test_frame_error();
        int d0, f0;
        d0 = done_n; f0 = fe_n;
        send_frame(8'h3C, 1'b0, 16, 16);
        repeat (40) @(negedge clk_div);
        n_total++; if (fe_n - f0 !== 1) $display("FAIL ferr_count got %0d want 1", fe_n - f0); else n_pass++;
        n_total++; if (done_n - d0 !== 0) $display("FAIL ferr_done got %0d want 0", done_n - d0); else n_pass++;
        n_total++; if (dout !== 8'hA5) $display("FAIL ferr_dout got %h want a5", dout); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL ferr_busy got %b want 0", busy); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int d0, f0;
        d0 = done_n; f0 = fe_n;
        send_frame(8'h00, 1'b1, 16, 16);
        send_frame(8'hFF, 1'b1, 16, 16);
        repeat (20) @(negedge clk_div);
        n_total++; if (done_n - d0 !== 2) $display("FAIL b2b_done_count got %0d want 2", done_n - d0); else n_pass++;
        n_total++;
        if (dq.size() < 2 || dq[dq.size()-2] !== 8'h00)
            $display("FAIL b2b_first_dout got %h want 00", (dq.size() > 1) ? dq[dq.size()-2] : 8'hxx);
        else n_pass++;
        n_total++; if (last_dout() !== 8'hFF) $display("FAIL b2b_second_dout got %h want ff", last_dout()); else n_pass++;
        n_total++;
        if (dt.size() < 2 || dt[dt.size()-1] - dt[dt.size()-2] !== 160)
            $display("FAIL b2b_spacing got %0d want 160", (dt.size() > 1) ? dt[dt.size()-1] - dt[dt.size()-2] : -1);
        else n_pass++;
        n_total++; if (fe_n - f0 !== 0) $display("FAIL b2b_frame_err got %0d want 0", fe_n - f0); else n_pass++;
    endtask

    task automatic test_reset_midframe();
        int d0, f0;
        logic [7:0] b;
        b = 8'h81;
        d0 = done_n; f0 = fe_n;
        rx = 1'b0;
        repeat (16) @(negedge clk_div);
        for (int i = 0; i < 4; i++) begin
            rx = b[i];
            repeat (16) @(negedge clk_div);
        end
        rx = b[4];
        repeat (8) @(negedge clk_div);
        rst_n = 1'b0;
        rx    = 1'b1;
        @(negedge clk_div);
        n_total++; if (busy !== 1'b0) $display("FAIL rstmid_busy got %b want 0", busy); else n_pass++;
        n_total++; if (dout !== 8'h00) $display("FAIL rstmid_dout got %h want 00", dout); else n_pass++;
        rst_n = 1'b1;
        repeat (30) @(negedge clk_div);
        n_total++; if (done_n - d0 !== 0) $display("FAIL rstmid_done got %0d want 0", done_n - d0); else n_pass++;
        n_total++; if (fe_n - f0 !== 0) $display("FAIL rstmid_frame_err got %0d want 0", fe_n - f0); else n_pass++;
        send_frame(8'h42, 1'b1, 16, 16);
        repeat (20) @(negedge clk_div);
        n_total++; if (done_n - d0 !== 1) $display("FAIL rstmid_next_done got %0d want 1", done_n - d0); else n_pass++;
        n_total++; if (dout !== 8'h42) $display("FAIL rstmid_next_dout got %h want 42", dout); else n_pass++;
        n_total++; if (fe_n - f0 !== 0) $display("FAIL rstmid_next_frame_err got %0d want 0", fe_n - f0); else n_pass++;
    endtask

    task automatic test_jitter();
        int d0, f0;
        d0 = done_n; f0 = fe_n;
        send_frame(8'h55, 1'b1, 15, 17);
        repeat (20) @(negedge clk_div);
        n_total++; if (done_n - d0 !== 1) $display("FAIL jitter_a_done got %0d want 1", done_n - d0); else n_pass++;
        n_total++; if (dout !== 8'h55) $display("FAIL jitter_a_dout got %h want 55", dout); else n_pass++;
        n_total++; if (fe_n - f0 !== 0) $display("FAIL jitter_a_frame_err got %0d want 0", fe_n - f0); else n_pass++;
        send_frame(8'h55, 1'b1, 17, 15);
        repeat (20) @(negedge clk_div);
        n_total++; if (done_n - d0 !== 2) $display("FAIL jitter_b_done got %0d want 2", done_n - d0); else n_pass++;
        n_total++; if (fe_n - f0 !== 0) $display("FAIL jitter_b_frame_err got %0d want 0", fe_n - f0); else n_pass++;
        n_total++; if (both_n !== 0) $display("FAIL pulses_overlap got %0d want 0", both_n); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_frame();
        test_glitch();
        test_frame_error();
        test_back_to_back();
        test_reset_midframe();
        test_jitter();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
